// File: rtl/trace_axis_width_converter_pkg.sv
// trace_axis_width_converter_pkg: shared widths, converter state type and a ceiling-divide helper
package trace_axis_width_converter_pkg;
  localparam int AXI_DATA_WIDTH = 200;
  localparam int TRACE_OUT_AXI_WIDTH = 64;
  typedef enum logic {WC_IDLE, WC_SEND} width_conv_state_t;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/trace_axis_width_converter_if.sv
// trace_axis_width_converter_if: AXI-Stream bundle (tvalid/tready/tdata/tlast); master drives, slave accepts
interface trace_axis_width_converter_if #(parameter int W = 64) ();
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;
  modport master(output tvalid, tdata, tlast, input tready);
  modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/trace_axis_width_converter.sv
// trace_axis_width_converter: splits each wide trace packet into ceil(IN/OUT) narrow beats, LSB slice first; ports: clk, rst (async high), s_axis (wide in), m_axis (narrow out), pkt_count, busy
module trace_axis_width_converter
  import trace_axis_width_converter_pkg::*;
#(
  parameter int IN_WIDTH           = AXI_DATA_WIDTH,
  parameter int OUT_WIDTH          = TRACE_OUT_AXI_WIDTH,
  parameter bit TLAST_EVERY_PACKET = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  trace_axis_width_converter_if.slave           s_axis,
  trace_axis_width_converter_if.master          m_axis,
  output logic [31:0]                           pkt_count,
  output logic                                  busy
);
  localparam int BEATS = ceil_div(IN_WIDTH, OUT_WIDTH);
  localparam int IW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int HW = BEATS * OUT_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);
  localparam logic [0:0] ST_IDLE = WC_IDLE;
  localparam logic [0:0] ST_SEND = WC_SEND;
  logic [0:0]    r_state;
  logic [IW-1:0] r_beat_idx;
  logic [HW-1:0] r_hold;
  logic          r_held_last;
  logic [31:0]   r_pkt_count;
  logic          w_send;
  logic          w_last_beat;
  logic          w_m_hs;
  logic          w_s_hs;
  assign w_send      = r_state == ST_SEND;
  assign w_last_beat = w_send & (r_beat_idx == LAST_IDX);
  assign w_m_hs      = w_send & m_axis.tready;
  assign w_s_hs      = s_axis.tvalid & s_axis.tready;
  // Ready also opens on the final accepted beat so back-to-back packets leave no bubble
  assign s_axis.tready = ~rst & (~w_send | (w_last_beat & m_axis.tready));
  assign m_axis.tvalid = w_send;
  assign m_axis.tdata  = w_send ? r_hold[r_beat_idx * OUT_WIDTH +: OUT_WIDTH] : '0;
  assign m_axis.tlast  = w_last_beat & (r_held_last | TLAST_EVERY_PACKET);
  assign pkt_count     = r_pkt_count;
  assign busy          = w_send;
  // Hold is padded to whole beats; zero-extension keeps the unused top bits of the last beat at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beat_idx  <= '0;
      r_hold      <= '0;
      r_held_last <= 1'b0;
    end else if (w_s_hs) begin
      r_state     <= ST_SEND;
      r_beat_idx  <= '0;
      r_hold      <= HW'(s_axis.tdata);
      r_held_last <= s_axis.tlast;
    end else if (w_m_hs) begin
      r_state    <= w_last_beat ? ST_IDLE : ST_SEND;
      r_beat_idx <= w_last_beat ? r_beat_idx : r_beat_idx + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pkt_count <= '0;
    else if (w_m_hs & w_last_beat) r_pkt_count <= r_pkt_count + 1'b1;
  end
endmodule

// File: tb/tb_trace_axis_width_converter.sv
// tb_trace_axis_width_converter: random-stimulus check of three converter variants against a beat-queue reference model
module tb_trace_axis_width_converter;
  typedef struct {
    logic [63:0] d;
    logic        l;
    logic        f;
  } beat_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic [199:0] s_data = '0;
  logic         s_last = 1'b0;
  logic         m_ready = 1'b1;
  bit           bp = 1'b0;
  logic [31:0]  pc0, pc1, pc2;
  logic         bz0, bz1, bz2;
  int           checks = 0;
  int           failures = 0;
  beat_t        q[3][$];
  logic [31:0]  cnt[3];
  int           tl[3];
  logic         prev_stall[3];
  logic [63:0]  prev_d[3];
  logic         prev_l[3];
  trace_axis_width_converter_if #(.W(200)) s0 ();
  trace_axis_width_converter_if #(.W(200)) s1 ();
  trace_axis_width_converter_if #(.W(64))  s2 ();
  trace_axis_width_converter_if #(.W(64))  m0 ();
  trace_axis_width_converter_if #(.W(64))  m1 ();
  trace_axis_width_converter_if #(.W(64))  m2 ();
  assign s0.tvalid = s_valid;
  assign s0.tdata  = s_data;
  assign s0.tlast  = s_last;
  assign m0.tready = m_ready;
  assign s1.tvalid = s_valid;
  assign s1.tdata  = s_data;
  assign s1.tlast  = s_last;
  assign m1.tready = m_ready;
  assign s2.tvalid = s_valid;
  assign s2.tdata  = s_data[63:0];
  assign s2.tlast  = s_last;
  assign m2.tready = m_ready;
  trace_axis_width_converter #(.IN_WIDTH(200), .OUT_WIDTH(64), .TLAST_EVERY_PACKET(1'b0)) d0 (
    .clk(clk), .rst(rst), .s_axis(s0.slave), .m_axis(m0.master), .pkt_count(pc0), .busy(bz0));
  trace_axis_width_converter #(.IN_WIDTH(200), .OUT_WIDTH(64), .TLAST_EVERY_PACKET(1'b1)) d1 (
    .clk(clk), .rst(rst), .s_axis(s1.slave), .m_axis(m1.master), .pkt_count(pc1), .busy(bz1));
  trace_axis_width_converter #(.IN_WIDTH(64), .OUT_WIDTH(64), .TLAST_EVERY_PACKET(1'b0)) d2 (
    .clk(clk), .rst(rst), .s_axis(s2.slave), .m_axis(m2.master), .pkt_count(pc2), .busy(bz2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask
  // Model: an accepted wide packet becomes a queue of expected beats; every output handshake pops one
  task automatic mon(input int id, input int beats, input int inw, input bit tep, input logic sr,
                     input logic mv, input logic [63:0] md, input logic ml, input logic [31:0] pc,
                     input logic bz);
    logic [255:0] w;
    beat_t b;
    int n;
    n = q[id].size();
    chk($sformatf("d%0d_tvalid", id), 64'(mv), 64'(n != 0));
    chk($sformatf("d%0d_busy", id), 64'(bz), 64'(n != 0));
    chk($sformatf("d%0d_sready", id), 64'(sr), 64'(n == 0 || (n == 1 && m_ready)));
    chk($sformatf("d%0d_pktcnt", id), 64'(pc), 64'(cnt[id]));
    if (prev_stall[id]) begin
      chk($sformatf("d%0d_stall_data", id), md, prev_d[id]);
      chk($sformatf("d%0d_stall_last", id), 64'(ml), 64'(prev_l[id]));
    end
    prev_stall[id] = mv & ~m_ready;
    prev_d[id] = md;
    prev_l[id] = ml;
    if (mv && m_ready && n != 0) begin
      b = q[id].pop_front();
      chk($sformatf("d%0d_data", id), md, b.d);
      chk($sformatf("d%0d_last", id), 64'(ml), 64'(b.l));
      if (b.f) cnt[id] = cnt[id] + 1;
      if (ml) tl[id]++;
    end
    if (s_valid && sr) begin
      w = 256'(s_data);
      if (inw == 64) w[255:64] = '0;
      for (int k = 0; k < beats; k++) begin
        b.d = w[k*64 +: 64];
        b.f = k == beats - 1;
        b.l = b.f && (tep || s_last);
        q[id].push_back(b);
      end
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        q[i].delete();
        cnt[i] = '0;
        tl[i] = 0;
        prev_stall[i] = 1'b0;
      end
    end else begin
      mon(0, 4, 200, 1'b0, s0.tready, m0.tvalid, m0.tdata, m0.tlast, pc0, bz0);
      mon(1, 4, 200, 1'b1, s1.tready, m1.tvalid, m1.tdata, m1.tlast, pc1, bz1);
      mon(2, 1, 64, 1'b0, s2.tready, m2.tvalid, m2.tdata, m2.tlast, pc2, bz2);
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = bp ? 1'($urandom % 2) : 1'b1;
  end
  // lmode: 0 tlast low, 1 tlast high, 2 random with occasional idle gaps
  task automatic send(input int n, input int lmode, input logic [199:0] d0);
    for (int i = 0; i < n; i++) begin
      logic [223:0] r;
      int t;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      s_data = (i == 0 && d0 != '0) ? d0 : r[199:0];
      s_last = lmode == 2 ? 1'($urandom % 2) : (lmode == 1);
      s_valid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (s0.tready !== 1'b1 && t < 500);
      if (t >= 500) chk("send_timeout", 64'(s0.tready), 64'd1);
      @(posedge clk);
      #1;
      if (lmode == 2 && $urandom % 8 == 0) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b0;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 || q[2].size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    int run;
    int t;
    int tl0;
    int tl1;
    logic rdy_b3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m0.tvalid), 64'd0);
    chk("rst_tdata", m0.tdata, 64'd0);
    chk("rst_tlast", 64'(m0.tlast), 64'd0);
    chk("rst_sready", 64'(s0.tready), 64'd0);
    chk("rst_pktcnt", 64'(pc0), 64'd0);
    chk("rst_busy", 64'(bz0), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(1, 1, {8'h5A, 120'h1, 56'h0, 16'h0123});
    drain();
    chk("single_pktcnt", 64'(pc0), 64'd1);
    chk("single_tlast_count", 64'(tl[0]), 64'd1);
    run = 0;
    rdy_b3 = 1'b0;
    fork
      send(2, 1, '0);
      begin
        t = 0;
        while (m0.tvalid !== 1'b1 && t < 20) begin
          @(negedge clk);
          t++;
        end
        while (m0.tvalid === 1'b1 && run < 20) begin
          if (run == 3) rdy_b3 = s0.tready;
          run++;
          @(negedge clk);
        end
      end
    join
    chk("b2b_valid_run", 64'(run), 64'd8);
    chk("b2b_sready_beat3", 64'(rdy_b3), 64'd1);
    drain();
    bp = 1'b1;
    send(1000, 2, '0);
    bp = 1'b0;
    drain();
    chk("bp_pktcnt", 64'(pc0), 64'(cnt[0]));
    tl0 = tl[0];
    tl1 = tl[1];
    send(20, 0, '0);
    drain();
    chk("nolast_tep0", 64'(tl[0] - tl0), 64'd0);
    chk("nolast_tep1", 64'(tl[1] - tl1), 64'd20);
    send(1, 1, '0);
    t = 0;
    do begin
      @(posedge clk);
      #2;
      t++;
    end while (q[0].size() != 2 && t < 20);
    chk("reach_beat2", 64'(q[0].size()), 64'd2);
    rst = 1'b1;
    #1;
    chk("arst_tvalid", 64'(m0.tvalid), 64'd0);
    chk("arst_tdata", m0.tdata, 64'd0);
    chk("arst_tlast", 64'(m0.tlast), 64'd0);
    chk("arst_sready", 64'(s0.tready), 64'd0);
    chk("arst_pktcnt", 64'(pc0), 64'd0);
    chk("arst_busy", 64'(bz0), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(1, 1, '0);
    drain();
    chk("post_rst_pktcnt", 64'(pc0), 64'd1);
    @(posedge clk);
    #1;
    force d2.r_pkt_count = 32'hFFFF_FFFF;
    cnt[2] = 32'hFFFF_FFFF;
    #1;
    release d2.r_pkt_count;
    send(1, 1, '0);
    drain();
    chk("wrap_pktcnt", 64'(pc2), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
